// File: rtl/mips_mem_arbiter.sv
// mips_mem_arbiter: shares the single-port mips_memory between instruction fetch and load/store.
// Data has priority; a streak limit stops data traffic from starving a pending fetch.
module mips_mem_arbiter #(
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        active,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ready,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [3:0]  d_be,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ready,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_done,
    output logic [31:0] mem_address,
    output logic        mem_wr_en,
    output logic        mem_read_en,
    output logic [3:0]  mem_byte_en,
    output logic [31:0] mem_data_in,
    input  logic [31:0] mem_data_out
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;
    localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);
    state_e      state_q;
    logic        cmd_owner_q, cmd_we_q;
    logic [3:0]  cmd_be_q, streak_q, streak_d;
    logic [31:0] cmd_addr_q, cmd_wdata_q, i_rdata_q, d_rdata_q;
    logic        wr_en_q, rd_en_q, i_rvalid_q, d_rvalid_q, d_done_q;
    logic        can_grant, gnt_d, gnt_i, store_d;
    assign can_grant = state_q == IDLE && active;
    assign gnt_d     = can_grant && d_req && !(i_req && streak_q == STREAK_MAX);
    assign gnt_i     = can_grant && i_req && !gnt_d;
    assign store_d   = gnt_d && d_we;
    assign streak_d  = gnt_d ? (i_req ? streak_q + 4'(streak_q != STREAK_MAX) : 4'd0)
                     : gnt_i ? 4'd0 : streak_q;
    assign i_ready     = gnt_i;
    assign d_ready     = gnt_d;
    assign i_rvalid    = i_rvalid_q;
    assign d_rvalid    = d_rvalid_q;
    assign d_done      = d_done_q;
    // Read data is steered straight from the memory register so it lands with rvalid.
    assign i_rdata     = i_rvalid_q ? mem_data_out : i_rdata_q;
    assign d_rdata     = d_rvalid_q ? mem_data_out : d_rdata_q;
    assign mem_address = cmd_addr_q;
    assign mem_byte_en = cmd_be_q;
    assign mem_data_in = cmd_wdata_q;
    assign mem_wr_en   = wr_en_q;
    assign mem_read_en = rd_en_q;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cmd_owner_q <= 1'b0;
            cmd_we_q    <= 1'b0;
            cmd_be_q    <= 4'd0;
            cmd_addr_q  <= 32'd0;
            cmd_wdata_q <= 32'd0;
            streak_q    <= 4'd0;
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            i_rvalid_q  <= 1'b0;
            d_rvalid_q  <= 1'b0;
            d_done_q    <= 1'b0;
            i_rdata_q   <= 32'd0;
            d_rdata_q   <= 32'd0;
        end else begin
            streak_q   <= streak_d;
            wr_en_q    <= 1'b0;
            rd_en_q    <= 1'b0;
            i_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            d_done_q   <= 1'b0;
            case (state_q)
                IDLE: if (gnt_d || gnt_i) begin
                    state_q     <= ACCESS;
                    cmd_owner_q <= gnt_d;
                    cmd_we_q    <= store_d;
                    cmd_be_q    <= gnt_d ? d_be : 4'hf;
                    cmd_addr_q  <= gnt_d ? d_addr : i_addr;
                    cmd_wdata_q <= gnt_d ? d_wdata : cmd_wdata_q;
                    wr_en_q     <= store_d;
                    rd_en_q     <= !store_d;
                    d_done_q    <= store_d;
                end
                ACCESS: begin
                    state_q    <= cmd_we_q ? IDLE : RESP;
                    i_rvalid_q <= !cmd_owner_q && !cmd_we_q;
                    d_rvalid_q <= cmd_owner_q && !cmd_we_q;
                    d_done_q   <= cmd_owner_q && !cmd_we_q;
                end
                RESP: begin
                    state_q   <= IDLE;
                    i_rdata_q <= i_rvalid_q ? mem_data_out : i_rdata_q;
                    d_rdata_q <= d_rvalid_q ? mem_data_out : d_rdata_q;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mips_mem_arbiter.sv
// tb_mips_mem_arbiter: directed stimulus with a response scoreboard for mips_mem_arbiter,
// driving a small behavioural single-port memory with one-cycle read latency.
module tb_mips_mem_arbiter;
    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        active = 1'b0;
    logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [31:0] i_addr = 32'd0, d_addr = 32'd0, d_wdata = 32'd0;
    logic [3:0]  d_be = 4'd0;
    logic        i_ready, i_rvalid, d_ready, d_rvalid, d_done, mem_wr_en, mem_read_en;
    logic [31:0] i_rdata, d_rdata, mem_address, mem_data_in, mem_data_out;
    logic [3:0]  mem_byte_en;

    typedef struct {int kind; logic [31:0] data; int cyc;} exp_t;
    exp_t exp_q[$];
    int   checks = 0, errors = 0, cyc = 0, wr_cnt = 0;
    logic [31:0] tb_mem [256];
    bit   loaded = 0;

    mips_mem_arbiter #(.MAX_DATA_STREAK(4)) dut (
        .clk(clk), .reset_n(reset_n), .active(active),
        .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_done(d_done),
        .mem_address(mem_address), .mem_wr_en(mem_wr_en), .mem_read_en(mem_read_en),
        .mem_byte_en(mem_byte_en), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (!loaded) begin
            for (int a = 0; a < 256; a++) tb_mem[a] <= 32'd0;
            tb_mem[0] <= 32'h3C1DBFC0;
            tb_mem[5] <= 32'hAAAAAAAA;
            tb_mem[8] <= 32'h55555555;
            loaded <= 1'b1;
        end else begin
            for (int b = 0; b < 4; b++)
                if (mem_wr_en && mem_byte_en[b]) tb_mem[mem_address[9:2]][8*b +: 8] <= mem_data_in[8*b +: 8];
            if (mem_read_en) mem_data_out <= tb_mem[mem_address[9:2]];
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // kind 0: fetch data, 1: load data with done, 2: store done
    always @(negedge clk) begin : monitor
        int   k;
        exp_t e;
        if (reset_n) begin
            if (mem_wr_en) wr_cnt++;
            if (i_rvalid || d_rvalid || d_done) begin
                k = i_rvalid ? 0 : d_rvalid ? 1 : 2;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp: got kind %0d at cycle %0d, expected none", k, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("resp_kind", k, e.kind);
                    chk("resp_cycle", cyc, e.cyc);
                    if (k == 0) chk("i_rdata", i_rdata, e.data);
                    if (k == 1) begin
                        chk("d_rdata", d_rdata, e.data);
                        chk("load_done", d_done, 1);
                    end
                end
            end
        end
    end

    task automatic wait_rdy(input bit is_d, output bit ok, output int n);
        ok = 0;
        n = 0;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            if (is_d ? d_ready : i_ready) begin
                ok = 1;
                n = cyc;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: is_d=%0d got no ready, expected one within 50 cycles", is_d);
        end
    endtask

    task automatic fetch(input logic [31:0] a, input logic [31:0] exp);
        bit ok;
        int n;
        @(posedge clk); #1;
        i_req = 1; i_addr = a;
        wait_rdy(0, ok, n);
        @(posedge clk); #1;
        i_req = 0;
        if (ok) begin
            exp_q.push_back('{0, exp, n + 2});
            @(negedge clk);
            chk("fetch_access", {mem_read_en, mem_wr_en, mem_byte_en, mem_address}, {1'b1, 1'b0, 4'hf, a});
        end
    endtask

    task automatic store(input logic [31:0] a, input logic [3:0] be, input logic [31:0] w);
        bit ok;
        int n;
        @(posedge clk); #1;
        d_req = 1; d_we = 1; d_addr = a; d_be = be; d_wdata = w;
        wait_rdy(1, ok, n);
        @(posedge clk); #1;
        d_req = 0;
        if (ok) begin
            exp_q.push_back('{2, 32'd0, n + 1});
            @(negedge clk);
            chk("store_access", {mem_read_en, mem_wr_en, mem_byte_en, mem_address, mem_data_in},
                {1'b0, 1'b1, be, a, w});
        end
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] exp);
        bit ok;
        int n;
        @(posedge clk); #1;
        d_req = 1; d_we = 0; d_addr = a; d_be = 4'hf;
        wait_rdy(1, ok, n);
        @(posedge clk); #1;
        d_req = 0;
        if (ok) begin
            exp_q.push_back('{1, exp, n + 2});
            @(negedge clk);
            chk("load_access", {mem_read_en, mem_wr_en, mem_address}, {1'b1, 1'b0, a});
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(negedge clk);
        @(posedge clk); #1;
    endtask

    task automatic outputs_zero(input string tag);
        chk({tag, "_ctrl"}, {i_ready, d_ready, i_rvalid, d_rvalid, d_done, mem_wr_en, mem_read_en, mem_byte_en}, 0);
        chk({tag, "_addr_wdata"}, {mem_address, mem_data_in}, 0);
        chk({tag, "_rdata"}, {i_rdata, d_rdata}, 0);
    endtask

    initial begin
        bit ok;
        int n, cnt, ng, dbl, wr0;
        logic [9:0] seq;
        #2 reset_n = 0;
        @(negedge clk);
        outputs_zero("reset");
        @(negedge clk);
        #2 reset_n = 1;
        active = 1;

        fetch(32'hBFC00000, 32'h3C1DBFC0);
        drain();

        wr0 = wr_cnt;
        store(32'h10, 4'hf, 32'hDEADBEEF);
        drain();
        chk("store_wr_pulses", wr_cnt - wr0, 1);
        load(32'h10, 32'hDEADBEEF);
        store(32'h14, 4'b0011, 32'h12345678);
        load(32'h14, 32'hAAAA5678);
        drain();
        chk("i_rdata_hold", i_rdata, 32'h3C1DBFC0);
        chk("d_rdata_hold", d_rdata, 32'hAAAA5678);

        i_req = 1; i_addr = 32'hBFC00000;
        d_req = 1; d_we = 0; d_addr = 32'h10; d_be = 4'hf;
        seq = 0; ng = 0; dbl = 0;
        for (int k = 0; k < 80 && ng < 10; k++) begin
            @(negedge clk);
            if (i_ready && d_ready) dbl++;
            if (d_ready) begin
                seq = {seq[8:0], 1'b1}; ng++;
                exp_q.push_back('{1, 32'hDEADBEEF, cyc + 2});
            end else if (i_ready) begin
                seq = {seq[8:0], 1'b0}; ng++;
                exp_q.push_back('{0, 32'h3C1DBFC0, cyc + 2});
            end
        end
        @(posedge clk); #1;
        i_req = 0; d_req = 0;
        chk("grant_count", ng, 10);
        chk("grant_seq", seq, 10'b1111011110);
        chk("dual_ready", dbl, 0);
        drain();

        active = 0; i_req = 1; d_req = 1; d_we = 0; d_addr = 32'h10;
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (i_ready || d_ready) cnt++;
        end
        chk("gated_ready", cnt, 0);
        @(posedge clk); #1;
        active = 1;
        @(negedge clk);
        chk("active_grant", {d_ready, i_ready}, 2'b10);
        if (d_ready) exp_q.push_back('{1, 32'hDEADBEEF, cyc + 2});
        @(posedge clk); #1;
        i_req = 0; d_req = 0;
        drain();

        i_req = 1; i_addr = 32'hBFC00000;
        d_req = 1; d_we = 0; d_addr = 32'h14;
        wait_rdy(1, ok, n);
        chk("data_beats_fetch", i_ready, 0);
        @(posedge clk); #1;
        i_req = 0; d_req = 0;
        if (ok) exp_q.push_back('{1, 32'hAAAA5678, n + 2});
        @(negedge clk);
        chk("streak_after_data", dut.streak_q, 2);
        @(posedge clk); #1;
        i_req = 1;
        @(negedge clk);
        chk("resp_no_iready", i_ready, 0);
        @(negedge clk);
        chk("idle_iready", i_ready, 1);
        if (i_ready) exp_q.push_back('{0, 32'h3C1DBFC0, cyc + 2});
        @(posedge clk); #1;
        i_req = 0;
        @(negedge clk);
        chk("streak_cleared", dut.streak_q, 0);
        drain();

        d_req = 1; d_we = 1; d_addr = 32'h20; d_be = 4'hf; d_wdata = 32'h0BADF00D;
        wait_rdy(1, ok, n);
        @(posedge clk); #1;
        d_req = 0;
        #1 reset_n = 0;
        #2;
        chk("rst_wr_en_drop", mem_wr_en, 0);
        chk("rst_no_done", d_done, 0);
        repeat (2) @(negedge clk);
        #2 reset_n = 1;
        @(negedge clk);
        outputs_zero("post_reset");
        chk("mem_unchanged", tb_mem[8], 32'h55555555);
        load(32'h20, 32'h55555555);
        drain();
        chk("queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at 100000 time units, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
